sprite_scheduler: RTL
=====================

# sprite_scheduler

Time-shares one 16-row sprite bitmap ROM among NUM_SPRITES hardware sprites. During each horizontal sync it sequences one ROM fetch per sprite for the upcoming scanline, then draws every active sprite as a 16-pixel, left/right-mirrored slice when the beam reaches its X position. It sits between the hvsync generator, the per-sprite position registers and the shared bitmap ROM, and replaces one renderer-plus-ROM per sprite.

## Interface
- NUM_SPRITES, 4, number of sprites served (2..8)
- clk  input  1  system/pixel clock, all logic on rising edge
- reset  input  1  asynchronous, active-low; 0 forces reset state immediately
- hpos  input  9  beam horizontal position from hvsync generator
- vpos  input  9  beam vertical position from hvsync generator
- hsync  input  1  horizontal sync level; its rising edge opens the fetch window
- sprite_x  input  8*NUM_SPRITES  packed X positions, sprite i in bits [8i+7:8i]
- sprite_y  input  8*NUM_SPRITES  packed Y positions, same packing
- rom_addr  output  4  registered row address to shared combinational ROM
- rom_bits  input  8  row data from ROM, valid same cycle as rom_addr
- gfx  output  NUM_SPRITES  registered per-sprite pixel
- any_gfx  output  1  OR of gfx
- gfx_id  output  3  index of lowest-numbered sprite with gfx set; 0 when none
- busy  output  1  1 while a fetch sequence runs

## Operation
- Reset values: rom_addr=0, gfx=0, busy=0, all line_active=0, line_bits=0, all draw counters idle, FSM=IDLE, hsync_d=0.
- Edge detect: hsync_d registers hsync; rise = hsync & ~hsync_d.
- FSM states: IDLE, SETUP, FETCH. Index register idx (3 bits).
- IDLE: on rise -> SETUP, idx=0. A rise while in SETUP/FETCH is ignored.
- SETUP: dy = (vpos + 1) - {1'b0, sprite_y[idx]}, 9-bit modulo 512. rom_addr <= dy[3:0]; hit[idx] <= (dy < 16). -> FETCH.
- FETCH: line_bits[idx] <= rom_bits; line_active[idx] <= hit[idx]. If idx==NUM_SPRITES-1 -> IDLE, else idx+1 and -> SETUP.
- busy = (FSM != IDLE).
- A fetch prepares line vpos+1. Sprite i is visible on lines sprite_y..sprite_y+15, with line numbers taken mod 512. No special case at frame wrap.
- Draw, per sprite i: hstart_i = line_active[i] & (hpos == {1'b0, sprite_x[i]}).
  - On hstart_i with counter idle: counter p=0 and running.
  - Each running cycle: gfx[i] <= line_bits[i][p<8 ? p : 15-p], then p+1. Counter stops after p=15.
  - When not running: gfx[i] <= 0.
  - A FETCH of sprite i aborts its running draw, so gfx[i] is 0 from the next cycle on.
  - hstart_i while running is ignored.
- any_gfx and gfx_id are combinational from the gfx register.

## Timing
- Rise is seen at edge E0. Sprite i: rom_addr is valid after edge E(1+2i), and line_bits are latched at edge E(2+2i). busy drops after edge E(2·NUM_SPRITES), i.e. 8 cycles for the default.
- Draw: hstart_i is true at edge D0. Pixel p appears on gfx[i] after edge D(p+1), for p=0..15. gfx[i]=0 after D17.
- Line data changes only in FETCH, so a sprite drawn on a line uses the bits fetched at the previous hsync.
- Reset asserted mid-fetch or mid-draw clears everything. The first fetch happens at the next rise after release.

## Structure
- Shared package holds state encoding (IDLE/SETUP/FETCH), SPRITE_H=16 and SPRITE_W=16.
- Sub-module sprite_line_drawer is instantiated NUM_SPRITES times. It holds the 8-bit line register, the active flag and the 4-bit counter, and produces the mirrored pixel. Inputs: clk, reset, load, load_active, load_bits, hstart; output gfx.
- The scheduler top holds the FSM, the dy subtractor, the rom_addr register and the priority encoder.

## Test plan
- Sprite 0 at x=20, y=10, ROM row 0 = 8'b0000_0001; rise at vpos=9 -> on line 10, gfx[0]=1 at hpos 21 and at hpos 36 (mirrored); other gfx bits stay 0.
- Bottom boundary: y=10, hsync rise at vpos=24 (dy=15) -> row 15 is fetched and drawn; rise at vpos=25 (dy=16) -> line_active=0 and gfx stays 0.
- Overlap: sprites 1 and 2 both at x=40, y=0, all-ones rows -> gfx=4'b0110 for 16 cycles, gfx_id=1, any_gfx=1.
- Fetch sequencing: sprite_y = 0,1,2,3 with vpos=4 -> rom_addr sequence 5,4,3,2 on alternate cycles; busy high exactly 8 cycles.
- Second hsync rise injected 3 cycles after the first -> ignored; sequence and busy length unchanged.
- reset=0 during FETCH of sprite 2 -> all outputs 0 immediately; after release, no drawing until the next rise.

Source files
------------

// File: rtl/sprite_scheduler_pkg.sv
// Shared definitions for the sprite scheduler and its per-sprite line drawers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sprite_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FETCH = 2'd2
    } state_t;

    localparam int SPRITE_H = 16;
    localparam int SPRITE_W = 16;

endpackage

// File: rtl/sprite_line_drawer.sv
// Holds one sprite's fetched row and emits it as a 16-pixel left/right-mirrored slice.
// Latency: pixel p appears on gfx p+2 cycles after the cycle in which hstart is seen.
// Backpressure: none; hstart while drawing is ignored, a load aborts the draw.
module sprite_line_drawer
    import sprite_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       load_active,
    input  logic [7:0] load_bits,
    input  logic       hstart,
    output logic       gfx
);

    logic [7:0] line_bits;
    logic       line_active;
    logic [3:0] p;
    logic       running;
    logic [2:0] col;

    // Second half of the slice walks the row backwards: 15-p == ~p[2:0] for p >= 8.
    assign col = p[3] ? ~p[2:0] : p[2:0];

    // Row latch, draw counter and registered pixel output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_bits   <= 8'd0;
            line_active <= 1'b0;
            p           <= 4'd0;
            running     <= 1'b0;
            gfx         <= 1'b0;
        end else if (load) begin
            line_bits   <= load_bits;
            line_active <= load_active;
            p           <= 4'd0;
            running     <= 1'b0;
            gfx         <= 1'b0;
        end else if (running) begin
            gfx <= line_bits[col];
            p   <= p + 4'd1;
            if (p == 4'(SPRITE_W - 1)) begin
                running <= 1'b0;
            end
        end else begin
            gfx <= 1'b0;
            if (hstart && line_active) begin
                running <= 1'b1;
                p       <= 4'd0;
            end
        end
    end

endmodule

// File: rtl/sprite_scheduler.sv
// Time-shares one 16-row bitmap ROM among NUM_SPRITES sprites: one fetch per sprite per hsync.
// Latency: rom_addr for sprite i valid 2i+2 cycles after hsync rises; busy lasts 2*NUM_SPRITES cycles.
// Backpressure: none; an hsync rise during a running fetch sequence is dropped.
module sprite_scheduler
    import sprite_scheduler_pkg::*;
#(
    parameter int NUM_SPRITES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [8:0]               hpos,
    input  logic [8:0]               vpos,
    input  logic                     hsync,
    input  logic [8*NUM_SPRITES-1:0] sprite_x,
    input  logic [8*NUM_SPRITES-1:0] sprite_y,
    output logic [3:0]               rom_addr,
    input  logic [7:0]               rom_bits,
    output logic [NUM_SPRITES-1:0]   gfx,
    output logic                     any_gfx,
    output logic [2:0]               gfx_id,
    output logic                     busy
);

    state_t     state;
    logic [2:0] idx;
    logic       hit;
    logic       hsync_d;
    logic       rise;
    logic [8:0] dy;
    logic [7:0] y_tab [8];

    // Padded to 8 entries so a 3-bit idx always selects a defined Y.
    for (genvar g = 0; g < 8; g++) begin : gen_ytab
        if (g < NUM_SPRITES) begin : gen_used
            assign y_tab[g] = sprite_y[8*g +: 8];
        end else begin : gen_pad
            assign y_tab[g] = 8'd0;
        end
    end

    assign rise = hsync & ~hsync_d;
    // Fetch prepares the next line, so the row offset is taken against vpos+1 (mod 512).
    assign dy   = (vpos + 9'd1) - {1'b0, y_tab[idx]};
    assign busy = (state != IDLE);

    // Fetch sequencer: SETUP drives the ROM address, FETCH hands the row to drawer idx.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= 3'd0;
            rom_addr <= 4'd0;
            hit      <= 1'b0;
            hsync_d  <= 1'b0;
        end else begin
            hsync_d <= hsync;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= SETUP;
                        idx   <= 3'd0;
                    end
                end
                SETUP: begin
                    rom_addr <= dy[3:0];
                    hit      <= (dy < 9'(SPRITE_H));
                    state    <= FETCH;
                end
                FETCH: begin
                    if (idx == 3'(NUM_SPRITES - 1)) begin
                        state <= IDLE;
                    end else begin
                        idx   <= idx + 3'd1;
                        state <= SETUP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : gen_drawer
        logic load_g;
        logic hstart_g;

        assign load_g   = (state == FETCH) && (idx == 3'(g));
        assign hstart_g = (hpos == {1'b0, sprite_x[8*g +: 8]});

        sprite_line_drawer u_drawer (
            .clk         (clk),
            .reset       (reset),
            .load        (load_g),
            .load_active (hit),
            .load_bits   (rom_bits),
            .hstart      (hstart_g),
            .gfx         (gfx[g])
        );
    end

    assign any_gfx = |gfx;

    // Priority encoder: lowest-numbered visible sprite wins, 0 when nothing is drawn.
    always_comb begin
        gfx_id = 3'd0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (gfx[i]) begin
                gfx_id = 3'(i);
            end
        end
    end

endmodule
